// File: rtl/note_entry_if.sv
// Button/note bus between the note entry stage and its neighbours.
// Port summary: btn_up/btn_down/btn_oct are raw buttons into note_entry;
// note/octave/ld_note/busy are the outputs consumed by the note drawer.
interface note_entry_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_oct;
   logic [3:0] note;
   logic [1:0] octave;
   logic       ld_note;
   logic       busy;

   // note_entry drives the note side and samples the buttons
   modport master (
      input  btn_up,
      input  btn_down,
      input  btn_oct,
      output note,
      output octave,
      output ld_note,
      output busy
   );

   // button source / drawer side
   modport slave (
      output btn_up,
      output btn_down,
      output btn_oct,
      input  note,
      input  octave,
      input  ld_note,
      input  busy
   );
endinterface

// File: rtl/note_entry.sv
// Purpose: sync + debounce three buttons, step note/octave, issue rate-limited ld_note loads.
// Latency: raw edge to ld_note is 4 + DEBOUNCE_CYCLES cycles when idle; first load INIT_HOLDOFF_CYCLES+1 after reset.
// Backpressure: none upstream; changes during hold-off coalesce into one deferred load.
// Ports: clk, reset (async active-high); bus (master): btn_up/btn_down/btn_oct in,
//        note[3:0], octave[1:0], ld_note, busy out.
module note_entry #(
   parameter int DEBOUNCE_CYCLES     = 250000,
   parameter int HOLDOFF_CYCLES      = 1024,
   parameter int INIT_HOLDOFF_CYCLES = 20000
) (
   input  logic          clk,
   input  logic          reset,
   note_entry_if.master  bus
);

   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HO_MAX = (HOLDOFF_CYCLES > INIT_HOLDOFF_CYCLES) ? HOLDOFF_CYCLES
                                                                  : INIT_HOLDOFF_CYCLES;
   localparam int HO_W   = (HO_MAX > 1) ? $clog2(HO_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HO_W-1:0] INIT_LAST = HO_W'(INIT_HOLDOFF_CYCLES - 1);
   localparam logic [HO_W-1:0] HOLD_LAST = HO_W'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // bit 0 = up, bit 1 = down, bit 2 = oct
   logic [2:0]      raw;
   logic [2:0]      sync1;
   logic [2:0]      sync2;
   logic [2:0]      stable;
   logic [2:0]      stable_d;
   logic [2:0]      press;
   logic [DB_W-1:0] db_cnt [3];

   logic [3:0]      note_w;
   logic [1:0]      oct_w;
   logic [3:0]      note_nx;
   logic [1:0]      oct_nx;
   logic            step;
   logic            pending;

   state_t          state;
   state_t          state_nx;
   logic [HO_W-1:0] ho_cnt;
   logic [HO_W-1:0] ho_cnt_nx;
   logic            load;

   logic [3:0]      note_r;
   logic [1:0]      oct_r;
   logic            ld_r;

   assign raw = {bus.btn_oct, bus.btn_down, bus.btn_up};

   // ---------------- synchroniser + debounce ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // release edges are deliberately ignored
   assign press = stable & ~stable_d;

   // ---------------- note / octave stepping ----------------
   always_comb begin
      note_nx = note_w;
      oct_nx  = oct_w;
      step    = 1'b0;
      // simultaneous up and down cancel and record nothing
      if (press[0] && !press[1]) begin
         note_nx = (note_w == 4'd12) ? 4'd1 : note_w + 4'd1;
         step    = 1'b1;
      end else if (press[1] && !press[0]) begin
         note_nx = (note_w == 4'd1) ? 4'd12 : note_w - 4'd1;
         step    = 1'b1;
      end
      if (press[2]) begin
         oct_nx = oct_w + 2'd1;
         step   = 1'b1;
      end
   end

   // ---------------- load-pacing FSM ----------------
   always_comb begin
      state_nx  = state;
      ho_cnt_nx = ho_cnt;
      load      = 1'b0;
      case (state)
         S_INIT: begin
            if (ho_cnt == INIT_LAST) begin
               state_nx  = S_IDLE;
               ho_cnt_nx = '0;
            end else begin
               ho_cnt_nx = ho_cnt + 1'b1;
            end
         end
         S_IDLE: begin
            if (pending) begin
               load      = 1'b1;
               ho_cnt_nx = '0;
               state_nx  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (ho_cnt == HOLD_LAST) begin
               state_nx  = S_IDLE;
               ho_cnt_nx = '0;
            end else begin
               ho_cnt_nx = ho_cnt + 1'b1;
            end
         end
         default: begin
            state_nx  = S_INIT;
            ho_cnt_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_INIT;
         ho_cnt  <= '0;
         note_w  <= 4'd1;
         oct_w   <= 2'd0;
         pending <= 1'b1;
         note_r  <= 4'd1;
         oct_r   <= 2'd0;
         ld_r    <= 1'b0;
      end else begin
         state  <= state_nx;
         ho_cnt <= ho_cnt_nx;
         note_w <= note_nx;
         oct_w  <= oct_nx;
         // ld_note is registered alongside note/octave so the drawer sees
         // the new values in the same cycle as the pulse. A step landing in
         // the load cycle is not part of this load, so it keeps pending set.
         ld_r   <= load;
         if (load) begin
            note_r <= note_w;
            oct_r  <= oct_w;
         end
         if (step)      pending <= 1'b1;
         else if (load) pending <= 1'b0;
      end
   end

   assign bus.note    = note_r;
   assign bus.octave  = oct_r;
   assign bus.ld_note = ld_r;
   assign bus.busy    = (state != S_IDLE);

endmodule
